// File: rtl/mem_access_seq.sv
// mem_access_seq: sequences LSU byte/half/word requests into one or two aligned word accesses on a sync-read memory
module mem_access_seq (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_wren,
  input  logic        i_req_signed,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_mem_en,
  output logic        o_mem_wren,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_bmask,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  output logic        o_busy
);
  localparam logic [1:0] IDLE = 2'd0, LO = 2'd1, HI = 2'd2, DONE = 2'd3;
  logic [1:0]  state, size, off;
  logic [31:0] addr, wdata, lo_word, shifted, load;
  logic        wren, sgn, act, in_range, split, hi_ok;
  logic [29:0] widx;
  logic [3:0]  lane;
  logic [7:0]  mask8;
  logic [63:0] pair;
  logic [5:0]  hi_sh;
  always_comb begin
    act      = !i_reset;
    off      = addr[1:0];
    in_range = addr <= 32'h0000_07FF;
    split    = (size[1] && off != 2'd0) || (size == 2'b01 && off == 2'd3);
    widx     = addr[31:2] + 30'd1;
    hi_ok    = widx <= 30'h1FF;
    lane     = size[1] ? 4'hF : size[0] ? 4'h3 : 4'h1;
    mask8    = {4'h0, lane} << off;
    hi_sh    = 6'd32 - {1'b0, off, 3'b000};
    pair     = split ? {hi_ok ? i_mem_rdata : 32'h0, lo_word} : {32'h0, i_mem_rdata};
    shifted  = 32'(pair >> {off, 3'b000});
    load     = size[1] ? shifted :
               size[0] ? {{16{sgn & shifted[15]}}, shifted[15:0]} :
                         {{24{sgn & shifted[7]}}, shifted[7:0]};
    o_req_ready = act && state == IDLE;
    o_busy      = act && state != IDLE;
    o_rsp_valid = act && state == DONE;
    o_rsp_rdata = (o_rsp_valid && !wren && in_range) ? load : 32'h0;
    o_mem_en    = act && (state == LO || (state == HI && hi_ok));
    o_mem_wren  = o_mem_en && wren;
    o_mem_addr  = state == HI ? {2'b00, widx} : {2'b00, addr[31:2]};
    o_mem_bmask = !o_mem_en ? 4'h0 : state == HI ? mask8[7:4] : mask8[3:0];
    o_mem_wdata = state == HI ? wdata >> hi_sh : wdata << {off, 3'b000};
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= IDLE;
      addr    <= 32'h0;
      wdata   <= 32'h0;
      size    <= 2'b00;
      wren    <= 1'b0;
      sgn     <= 1'b0;
      lo_word <= 32'h0;
    end else if (state == IDLE) begin
      if (i_req_valid) begin
        addr  <= i_req_addr;
        wdata <= i_req_wdata;
        size  <= i_req_size;
        wren  <= i_req_wren;
        sgn   <= i_req_signed;
        state <= i_req_addr <= 32'h0000_07FF ? LO : DONE;
      end
    end else if (state == LO) begin
      state <= split ? HI : DONE;
    end else if (state == HI) begin
      lo_word <= i_mem_rdata;
      state   <= DONE;
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: doc/mem_access_seq.md
MEM_ACCESS_SEQ -- requirements
Module: mem_access_seq

Interface
REQ-001 SHALL have port i_clk, input, 1: single clock; all state changes on its rising edge.
REQ-002 SHALL have port i_reset, input, 1: synchronous, active-high reset.
REQ-003 SHALL have port i_req_valid, input, 1: LSU request present.
REQ-004 SHALL have port o_req_ready, output, 1: request accepted when i_req_valid and o_req_ready are both high at a clock edge.
REQ-005 SHALL have port i_req_addr, input, 32: byte address.
REQ-006 SHALL have port i_req_wdata, input, 32: store data, right-justified.
REQ-007 SHALL have port i_req_size, input, 2: 00 byte, 01 half, 10 word; 11 treated as word.
REQ-008 SHALL have ports i_req_wren, input, 1 (store) and i_req_signed, input, 1 (sign-extend load).
REQ-009 SHALL have ports o_rsp_valid, output, 1 (one-cycle completion pulse) and o_rsp_rdata, output, 32 (load result; 0 for stores).
REQ-010 SHALL have port o_mem_en, output, 1: memory access strobe.
REQ-011 SHALL have port o_mem_wren, output, 1: write strobe, qualified by o_mem_en.
REQ-012 SHALL have ports o_mem_addr, output, 32 (word index) and o_mem_bmask, output, 4 (byte-lane enables).
REQ-013 SHALL have port o_mem_wdata, output, 32: lane-aligned write data.
REQ-014 SHALL have port i_mem_rdata, input, 32: single-port synchronous-read memory data, valid the cycle after an access with o_mem_en high.
REQ-015 SHALL have port o_busy, output, 1: high in every state except IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, LO, HI, DONE; o_req_ready = (state==IDLE) and not i_reset.
REQ-017 SHALL capture addr, wdata, size, wren and signed into registers on acceptance; the request ports are ignored at all other times.
REQ-018 SHALL classify in-range as addr <= 0x0000_07FF; out-of-range: IDLE->DONE, no o_mem_en, o_rsp_rdata=0, o_rsp_valid at T+1 (T = acceptance edge).
REQ-019 SHALL mark an access split when word size has offset != 0, or half size has offset == 3; half at offset 1 is not split.
REQ-020 SHALL drive, in LO: o_mem_en=1, o_mem_wren=captured wren, o_mem_addr=addr[31:2], bmask=low 4 bits of (lane mask << offset), wdata=wdata << 8*offset.
REQ-021 SHALL transition LO->HI if split, else LO->DONE.
REQ-022 SHALL drive, in HI: o_mem_addr=addr[31:2]+1, bmask=(lane mask << offset) >> 4, wdata=wdata >> 8*(4-offset); low-word rdata captured in this state.
REQ-023 SHALL suppress the HI access (o_mem_en=0) when addr[31:2]+1 > 0x1FF; the missing high bytes read as 0 and are not stored.
REQ-024 SHALL assert o_rsp_valid for exactly one cycle in DONE, then go to IDLE.
REQ-025 SHALL form load data in DONE as ({hi,lo} >> 8*offset) truncated to size, sign-extended if captured signed, else zero-extended; hi = i_mem_rdata and lo = captured word for split, lo = i_mem_rdata for unsplit.
REQ-026 SHALL give in-range latency: unsplit o_rsp_valid at T+2, split at T+3; next acceptance no earlier than the cycle after DONE.
REQ-027 SHALL hold o_mem_en=0, o_mem_wren=0, o_mem_bmask=0 in IDLE and DONE.
REQ-028 SHALL drive o_rsp_rdata=0 whenever o_rsp_valid is low or the request was a store.

Reset
REQ-029 SHALL force, at any reset edge, state=IDLE and all capture registers=0.
REQ-030 SHALL force, while i_reset is high, o_req_ready=0, o_rsp_valid=0, o_mem_en=0, o_mem_wren=0 and o_busy=0.
REQ-031 SHALL abandon any in-flight access at reset with no response; the first request after reset release is accepted normally.

Verification
REQ-032 SHALL cover: word store 0xDEADBEEF @0x10 -> one LO write, addr 0x4, bmask 1111; rsp_valid at T+2.
REQ-033 SHALL cover: word load @0x13 with mem[4]=0x44332211 and mem[5]=0x88776655 -> LO addr 4, HI addr 5; rdata 0x77665544 at T+3.
REQ-034 SHALL cover: signed half load @0x23 with mem[8] byte3=0x80 and mem[9] byte0=0xFF -> 0xFFFFFF80; same load unsigned -> 0x0000FF80.
REQ-035 SHALL cover: half store 0xABCD @0x05 -> single write, bmask 0110, wdata 0x00ABCD00; store @0x7FD word -> LO bmask 1110 only, no HI access.
REQ-036 SHALL cover: load @0x1000_0000 -> no o_mem_en, rdata 0 at T+1; a request held during busy is not accepted until IDLE.
REQ-037 SHALL cover: reset asserted in HI -> next cycle IDLE, no rsp_valid, o_mem_en=0; a subsequent request completes with correct data.
